// File: rtl/data_mem_resp.sv
// Data-memory responder: one request per handshake, byte-lane stores, right-justified
// loads, a configurable number of wait states and misalignment flagging.
module data_mem_resp #(
  parameter int SIZE        = 12,
  parameter int WAIT_STATES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            reqValid,
  output logic            reqReady,
  input  logic [2:0]      memCtrl,
  input  logic [SIZE-1:0] addr,
  input  logic [31:0]     wData,
  output logic            rspValid,
  output logic [31:0]     rData,
  output logic            rspErr
);

  localparam int         WORDS    = 2 ** (SIZE - 2);
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [2:0]      ctrl_q, ctrl_d;
  logic [SIZE-1:0] addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            rsp_err_q, rsp_err_d;

  logic [2:0]      op_ctrl;
  logic [SIZE-1:0] op_addr;
  logic [31:0]     op_wdata;
  logic [SIZE-3:0] word_idx;
  logic [1:0]      lane;
  logic            is_store, is_byte, is_half, is_word, misaligned;
  logic [31:0]     mem_word, shifted, load_data, store_bytes;
  logic [3:0]      byte_en;
  logic            accept, enter_resp, mem_we;

  logic [31:0]     mem [WORDS];

  assign reqReady = (state_q == S_IDLE) && !rst;
  assign accept   = reqValid && reqReady;
  assign rspValid = rsp_valid_q;
  assign rData    = rdata_q;
  assign rspErr   = rsp_err_q;

  // With zero wait states the access commits on the accept edge, so use the live request.
  always_comb begin
    if (state_q == S_IDLE) begin
      op_ctrl  = memCtrl;
      op_addr  = addr;
      op_wdata = wData;
    end else begin
      op_ctrl  = ctrl_q;
      op_addr  = addr_q;
      op_wdata = wdata_q;
    end
    word_idx = op_addr[SIZE-1:2];
    lane     = op_addr[1:0];
  end

  always_comb begin
    is_byte  = 1'b0;
    is_half  = 1'b0;
    is_word  = 1'b0;
    is_store = op_ctrl inside {3'b101, 3'b110, 3'b111};
    case (op_ctrl)
      3'b000, 3'b011, 3'b101: is_byte = 1'b1;
      3'b001, 3'b100, 3'b110: is_half = 1'b1;
      default:                is_word = 1'b1;
    endcase
    misaligned = (is_half && lane[0]) || (is_word && (lane != 2'b00));
  end

  always_comb begin
    mem_word  = mem[word_idx];
    shifted   = mem_word >> {lane, 3'b000};
    load_data = shifted;
    if (is_byte)      load_data = {24'b0, shifted[7:0]};
    else if (is_half) load_data = {16'b0, shifted[15:0]};

    store_bytes = op_wdata;
    byte_en     = 4'b1111;
    if (is_byte) begin
      store_bytes = {4{op_wdata[7:0]}};
      byte_en     = 4'b0001 << lane;
    end else if (is_half) begin
      store_bytes = {2{op_wdata[15:0]}};
      byte_en     = lane[1] ? 4'b1100 : 4'b0011;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ctrl_d      = ctrl_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rsp_err_d   = rsp_err_q;
    enter_resp  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          ctrl_d  = memCtrl;
          addr_d  = addr;
          wdata_d = wData;
          if (WAIT_STATES == 0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    rsp_valid_d = enter_resp;
    if (enter_resp) begin
      rdata_d   = (is_store || misaligned) ? 32'd0 : load_data;
      rsp_err_d = misaligned;
    end
    mem_we = enter_resp && is_store && !misaligned && !rst;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      ctrl_q      <= 3'd0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ctrl_q      <= ctrl_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // The array is deliberately left out of reset; only enabled lanes are touched.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[word_idx][i*8 +: 8] <= store_bytes[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp: four instances cover wait-state counts 1, 0, 3 and 2,
// sharing the request buses but each with its own valid and reset.
module tb_data_mem_resp;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b011;
  localparam logic [2:0] LHU = 3'b100;
  localparam logic [2:0] SB  = 3'b101;
  localparam logic [2:0] SH  = 3'b110;
  localparam logic [2:0] SW  = 3'b111;

  logic        clk;
  logic [3:0]  rst;
  logic [3:0]  reqValid;
  logic [3:0]  reqReady;
  logic [3:0]  rspValid;
  logic [3:0]  rspErr;
  logic [2:0]  memCtrl;
  logic [11:0] addr;
  logic [31:0] wData;
  logic [31:0] rData [4];

  int checks = 0;
  int errors = 0;

  data_mem_resp #(.SIZE(12), .WAIT_STATES(1)) dut_ws1 (
    .clk(clk), .rst(rst[0]), .reqValid(reqValid[0]), .reqReady(reqReady[0]),
    .memCtrl(memCtrl), .addr(addr), .wData(wData),
    .rspValid(rspValid[0]), .rData(rData[0]), .rspErr(rspErr[0]));

  data_mem_resp #(.SIZE(12), .WAIT_STATES(0)) dut_ws0 (
    .clk(clk), .rst(rst[1]), .reqValid(reqValid[1]), .reqReady(reqReady[1]),
    .memCtrl(memCtrl), .addr(addr), .wData(wData),
    .rspValid(rspValid[1]), .rData(rData[1]), .rspErr(rspErr[1]));

  data_mem_resp #(.SIZE(12), .WAIT_STATES(3)) dut_ws3 (
    .clk(clk), .rst(rst[2]), .reqValid(reqValid[2]), .reqReady(reqReady[2]),
    .memCtrl(memCtrl), .addr(addr), .wData(wData),
    .rspValid(rspValid[2]), .rData(rData[2]), .rspErr(rspErr[2]));

  data_mem_resp #(.SIZE(12), .WAIT_STATES(2)) dut_ws2 (
    .clk(clk), .rst(rst[3]), .reqValid(reqValid[3]), .reqReady(reqReady[3]),
    .memCtrl(memCtrl), .addr(addr), .wData(wData),
    .rspValid(rspValid[3]), .rData(rData[3]), .rspErr(rspErr[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // One complete transaction: handshake, bounded wait for the strobe, then check
  // latency (negedges after the accept edge), payload, busy state and one-cycle strobe.
  task automatic applyStimulus(input int d, input logic [2:0] ctrl, input logic [11:0] a,
                               input logic [31:0] w, input int expLat,
                               input logic [31:0] expData, input logic expErr,
                               input string tag);
    int n;
    int k;
    @(negedge clk);
    memCtrl     = ctrl;
    addr        = a;
    wData       = w;
    reqValid[d] = 1'b1;
    n = 0;
    while (!reqReady[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, " ready"}, 32'(reqReady[d]), 32'd1);
    @(posedge clk);
    #1;
    reqValid[d] = 1'b0;
    @(negedge clk);
    k = 0;
    while (!rspValid[d] && k < 20) begin
      @(negedge clk);
      k++;
    end
    checkOutput({tag, " latency"}, 32'(k), 32'(expLat));
    checkOutput({tag, " rData"}, rData[d], expData);
    checkOutput({tag, " rspErr"}, 32'(rspErr[d]), 32'(expErr));
    checkOutput({tag, " busy"}, 32'(reqReady[d]), 32'd0);
    @(negedge clk);
    checkOutput({tag, " strobe"}, 32'(rspValid[d]), 32'd0);
  endtask

  // Holds reqValid high and records the negedges at which reqReady is seen.
  task automatic measureSpacing(input int d, input int expSpacing, input int expReady,
                                input string tag);
    int idx [3];
    int nReady;
    nReady = 0;
    idx[0] = -100;
    idx[1] = -100;
    idx[2] = -100;
    @(negedge clk);
    memCtrl     = LW;
    addr        = 12'h000;
    wData       = 32'd0;
    reqValid[d] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (reqReady[d]) begin
        if (nReady < 3) idx[nReady] = i;
        nReady++;
      end
      @(negedge clk);
    end
    reqValid[d] = 1'b0;
    checkOutput({tag, " spacing1"}, 32'(idx[1] - idx[0]), 32'(expSpacing));
    checkOutput({tag, " spacing2"}, 32'(idx[2] - idx[1]), 32'(expSpacing));
    checkOutput({tag, " readyCount"}, 32'(nReady), 32'(expReady));
    repeat (8) @(negedge clk);
  endtask

  // Accepts a store on the WAIT_STATES=2 instance, then pulses reset `resetAt` negedges
  // after the accept edge; no strobe may follow.
  task automatic dropWithReset(input int resetAt, input logic [31:0] w, input string tag);
    int n;
    int strobes;
    @(negedge clk);
    memCtrl     = SW;
    addr        = 12'h020;
    wData       = w;
    reqValid[3] = 1'b1;
    n = 0;
    while (!reqReady[3] && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, " ready"}, 32'(reqReady[3]), 32'd1);
    @(posedge clk);
    #1;
    reqValid[3] = 1'b0;
    strobes = 0;
    for (int i = 0; i < resetAt; i++) begin
      @(negedge clk);
      if (rspValid[3]) strobes++;
    end
    @(negedge clk);
    rst[3] = 1'b1;
    #1;
    checkOutput({tag, " readyInReset"}, 32'(reqReady[3]), 32'd0);
    @(negedge clk);
    rst[3] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rspValid[3]) strobes++;
    end
    checkOutput({tag, " noStrobe"}, 32'(strobes), 32'd0);
  endtask

  initial begin
    rst      = 4'hF;
    reqValid = 4'h0;
    memCtrl  = LB;
    addr     = 12'h000;
    wData    = 32'd0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("reset reqReady", 32'(reqReady[0]), 32'd0);
    checkOutput("reset rspValid", 32'(rspValid[0]), 32'd0);
    checkOutput("reset rData", rData[0], 32'd0);
    checkOutput("reset rspErr", 32'(rspErr[0]), 32'd0);
    checkOutput("reset reqReady ws2", 32'(reqReady[3]), 32'd0);
    @(negedge clk);
    rst = 4'h0;
    #1;
    checkOutput("idle reqReady", 32'(reqReady[0]), 32'd1);

    $display("[TB] word store and load");
    applyStimulus(0, SW, 12'h010, 32'hDEADBEEF, 1, 32'd0, 1'b0, "sw 010");
    applyStimulus(0, LW, 12'h010, 32'd0, 1, 32'hDEADBEEF, 1'b0, "lw 010 a");

    $display("[TB] byte store");
    applyStimulus(0, SW, 12'h010, 32'h11223344, 1, 32'd0, 1'b0, "sw 010 b");
    applyStimulus(0, SB, 12'h013, 32'h000000AA, 1, 32'd0, 1'b0, "sb 013");
    applyStimulus(0, LW, 12'h010, 32'd0, 1, 32'hAA223344, 1'b0, "lw 010 b");
    applyStimulus(0, LBU, 12'h013, 32'd0, 1, 32'h000000AA, 1'b0, "lbu 013");
    applyStimulus(0, LB, 12'h013, 32'd0, 1, 32'h000000AA, 1'b0, "lb 013");
    applyStimulus(0, LB, 12'h010, 32'd0, 1, 32'h00000044, 1'b0, "lb 010");
    applyStimulus(0, LH, 12'h010, 32'd0, 1, 32'h00003344, 1'b0, "lh 010");

    $display("[TB] half store");
    applyStimulus(0, SH, 12'h012, 32'h0000CAFE, 1, 32'd0, 1'b0, "sh 012");
    applyStimulus(0, LHU, 12'h012, 32'd0, 1, 32'h0000CAFE, 1'b0, "lhu 012");
    applyStimulus(0, LH, 12'h012, 32'd0, 1, 32'h0000CAFE, 1'b0, "lh 012");
    applyStimulus(0, LW, 12'h010, 32'd0, 1, 32'hCAFE3344, 1'b0, "lw 010 c");
    applyStimulus(0, LBU, 12'h011, 32'd0, 1, 32'h00000033, 1'b0, "lbu 011");

    $display("[TB] misaligned accesses");
    applyStimulus(0, LW, 12'h011, 32'd0, 1, 32'd0, 1'b1, "lw 011 mis");
    applyStimulus(0, SH, 12'h013, 32'h0000FFFF, 1, 32'd0, 1'b1, "sh 013 mis");
    applyStimulus(0, SW, 12'h012, 32'hFFFFFFFF, 1, 32'd0, 1'b1, "sw 012 mis");
    applyStimulus(0, LHU, 12'h011, 32'd0, 1, 32'd0, 1'b1, "lhu 011 mis");
    applyStimulus(0, LW, 12'h010, 32'd0, 1, 32'hCAFE3344, 1'b0, "lw 010 d");

    $display("[TB] throughput");
    applyStimulus(1, SW, 12'h040, 32'h01020304, 0, 32'd0, 1'b0, "ws0 sw 040");
    applyStimulus(1, LH, 12'h042, 32'd0, 0, 32'h00000102, 1'b0, "ws0 lh 042");
    applyStimulus(2, SB, 12'h041, 32'h0000005A, 3, 32'd0, 1'b0, "ws3 sb 041");
    applyStimulus(2, LBU, 12'h041, 32'd0, 3, 32'h0000005A, 1'b0, "ws3 lbu 041");
    measureSpacing(1, 2, 6, "ws0");
    measureSpacing(2, 5, 3, "ws3");

    $display("[TB] reset while waiting");
    applyStimulus(3, SW, 12'h020, 32'hA5A5A5A5, 2, 32'd0, 1'b0, "ws2 sw 020");
    dropWithReset(0, 32'h12345678, "rst in wait");
    applyStimulus(3, LW, 12'h020, 32'd0, 2, 32'hA5A5A5A5, 1'b0, "ws2 lw 020 a");
    dropWithReset(1, 32'h0BADF00D, "rst before resp");
    applyStimulus(3, LW, 12'h020, 32'd0, 2, 32'hA5A5A5A5, 1'b0, "ws2 lw 020 b");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
